// File: rtl/sb_panel_regs.sv
// Slow-bus register slave for the panel scanner: control/status registers plus a double-buffered
// frame-buffer port with an auto-incrementing pointer. Define SB_FB_READBACK_EN to allow FB_DATA reads from RAM.
module sb_panel_regs #(
    parameter logic [15:0] ID_VALUE = 16'h5032,
    parameter int          FB_AW    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      sb_addr,
    input  logic             sb_wr,
    input  logic [15:0]      sb_wr_data,
    input  logic             sb_rd,
    output logic [15:0]      sb_rd_data,
    output logic             fb_wr_en,
    output logic [FB_AW-1:0] fb_wr_addr,
    output logic [15:0]      fb_wr_data,
    output logic             fb_rd_en,
    output logic [FB_AW-1:0] fb_rd_addr,
    input  logic [15:0]      fb_rd_data,
    input  logic             frame_done,
    output logic             display_en,
    output logic             front_buf,
    output logic [3:0]       brightness
);

    localparam logic [15:0] A_ID      = 16'd0;
    localparam logic [15:0] A_CTRL    = 16'd1;
    localparam logic [15:0] A_STATUS  = 16'd2;
    localparam logic [15:0] A_PTR     = 16'd3;
    localparam logic [15:0] A_FB_DATA = 16'd4;
    localparam logic [15:0] A_SCRATCH = 16'd5;

    logic             r_en;
    logic [3:0]       r_bright;
    logic             r_swap_pend;
    logic             r_front;
    logic             r_vsync;
    logic [FB_AW-1:0] r_ptr;
    logic [15:0]      r_scratch;
    logic [15:0]      r_rd_data;
    logic             r_fb_wr_en;
    logic [FB_AW-1:0] r_fb_wr_addr;
    logic [15:0]      r_fb_wr_data;

    logic             w_wr;
    logic             w_rd;
    logic [15:0]      w_addr;
    logic [15:0]      w_wdata;
    logic             w_rd_fb;
    logic             w_rd_wait;
    logic [15:0]      w_rd_mux;

`ifdef SB_FB_READBACK_EN
    typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_q_vld;
    logic        r_q_wr;
    logic [15:0] r_q_addr;
    logic [15:0] r_q_data;
    logic        w_q_load;

    // A strobe seen during RD_WAIT (or while a queued one is being replayed) is parked for one cycle.
    assign w_q_load = (sb_wr | sb_rd) & ((r_state == ST_RD_WAIT) | r_q_vld);

    always_comb begin
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_addr  = sb_addr;
        w_wdata = sb_wr_data;
        if (r_state == ST_IDLE) begin
            if (r_q_vld) begin
                w_wr    = r_q_wr;
                w_rd    = ~r_q_wr;
                w_addr  = r_q_addr;
                w_wdata = r_q_data;
            end else begin
                w_wr = sb_wr;
                w_rd = sb_rd & ~sb_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_vld  <= 1'b0;
            r_q_wr   <= 1'b0;
            r_q_addr <= 16'h0000;
            r_q_data <= 16'h0000;
        end else if (w_q_load) begin
            r_q_vld  <= 1'b1;
            r_q_wr   <= sb_wr;
            r_q_addr <= sb_addr;
            r_q_data <= sb_wr_data;
        end else if (r_q_vld && r_state == ST_IDLE) begin
            r_q_vld <= 1'b0;
        end
    end

    assign w_rd_fb = w_rd & (w_addr == A_FB_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_rd_fb) w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_wait  = (r_state == ST_RD_WAIT);
        fb_rd_en   = w_rd_wait;
        fb_rd_addr = w_rd_wait ? r_ptr : '0;
    end
`else
    assign w_wr       = sb_wr;
    assign w_rd       = sb_rd & ~sb_wr;
    assign w_addr     = sb_addr;
    assign w_wdata    = sb_wr_data;
    assign w_rd_fb    = 1'b0;
    assign w_rd_wait  = 1'b0;
    assign fb_rd_en   = 1'b0;
    assign fb_rd_addr = '0;
`endif

    always_comb begin
        w_rd_mux = 16'h0000;
        case (w_addr)
            A_ID:      w_rd_mux = ID_VALUE;
            A_CTRL:    w_rd_mux = {8'h00, r_bright, 2'b00, r_swap_pend, r_en};
            A_STATUS:  w_rd_mux = {14'h0000, r_front, r_vsync};
            A_PTR:     w_rd_mux = {{(16-FB_AW){1'b0}}, r_ptr};
            A_SCRATCH: w_rd_mux = r_scratch;
            default:   w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en         <= 1'b0;
            r_bright     <= 4'h0;
            r_ptr        <= '0;
            r_scratch    <= 16'h0000;
            r_rd_data    <= 16'h0000;
            r_fb_wr_en   <= 1'b0;
            r_fb_wr_addr <= '0;
            r_fb_wr_data <= 16'h0000;
        end else begin
            r_fb_wr_en <= 1'b0;
            if (w_rd_wait) begin
                r_rd_data <= fb_rd_data;
                r_ptr     <= r_ptr + FB_AW'(1);
            end else if (w_rd && !w_rd_fb) begin
                r_rd_data <= w_rd_mux;
            end
            if (w_wr) begin
                case (w_addr)
                    A_CTRL: begin
                        r_en     <= w_wdata[0];
                        r_bright <= w_wdata[7:4];
                    end
                    A_PTR:     r_ptr <= w_wdata[FB_AW-1:0];
                    A_FB_DATA: begin
                        r_fb_wr_en   <= 1'b1;
                        r_fb_wr_addr <= r_ptr;
                        r_fb_wr_data <= w_wdata;
                        r_ptr        <= r_ptr + FB_AW'(1);
                    end
                    A_SCRATCH: r_scratch <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Swap decisions use the registered swap_pend, so a same-cycle request waits for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swap_pend <= 1'b0;
            r_front     <= 1'b0;
            r_vsync     <= 1'b0;
        end else begin
            if (frame_done && r_swap_pend) r_front <= ~r_front;
            if (w_wr && w_addr == A_CTRL && w_wdata[1]) r_swap_pend <= 1'b1;
            else if (frame_done)                        r_swap_pend <= 1'b0;
            if (frame_done)                                    r_vsync <= 1'b1;
            else if (w_wr && w_addr == A_STATUS && w_wdata[0]) r_vsync <= 1'b0;
        end
    end

    assign sb_rd_data = r_rd_data;
    assign fb_wr_en   = r_fb_wr_en;
    assign fb_wr_addr = r_fb_wr_addr;
    assign fb_wr_data = r_fb_wr_data;
    assign display_en = r_en;
    assign front_buf  = r_front;
    assign brightness = r_bright;

endmodule

// File: tb/tb_sb_panel_regs.sv
// Bench for sb_panel_regs: scoreboard queues hold expected read data and expected RAM writes.
module tb_sb_panel_regs;
    localparam int FB_AW = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [15:0]      sb_addr = 16'h0;
    logic             sb_wr = 1'b0;
    logic [15:0]      sb_wr_data = 16'h0;
    logic             sb_rd = 1'b0;
    logic [15:0]      sb_rd_data;
    logic             fb_wr_en;
    logic [FB_AW-1:0] fb_wr_addr;
    logic [15:0]      fb_wr_data;
    logic             fb_rd_en;
    logic [FB_AW-1:0] fb_rd_addr;
    logic [15:0]      fb_rd_data;
    logic             frame_done = 1'b0;
    logic             display_en;
    logic             front_buf;
    logic [3:0]       brightness;

    logic [15:0] ram [0:2047];
    logic [15:0] exp_rd_q [$];
    logic [26:0] exp_wr_q [$];
    logic [26:0] obs_wr_q [$];
    int          rd_en_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] e;
    logic [26:0] ew, ow;

    always #5 clk = ~clk;

    // RAM model presents the addressed word while the read enable is high.
    assign fb_rd_data = fb_rd_en ? ram[fb_rd_addr] : 16'h0000;

    sb_panel_regs dut (
        .clk(clk), .rst_n(rst_n), .sb_addr(sb_addr), .sb_wr(sb_wr), .sb_wr_data(sb_wr_data),
        .sb_rd(sb_rd), .sb_rd_data(sb_rd_data), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
        .fb_wr_data(fb_wr_data), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
        .fb_rd_data(fb_rd_data), .frame_done(frame_done), .display_en(display_en),
        .front_buf(front_buf), .brightness(brightness)
    );

    always @(negedge clk) begin
        if (fb_wr_en) obs_wr_q.push_back({fb_wr_addr, fb_wr_data});
        if (fb_rd_en) rd_en_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk); sb_addr = a; sb_wr_data = d; sb_wr = 1'b1;
        @(negedge clk); sb_wr = 1'b0;
    endtask

    // Ends on the negedge after the sampling edge, i.e. where latency-1 data is visible.
    task automatic rd(input logic [15:0] a, input logic [15:0] exp);
        exp_rd_q.push_back(exp);
        @(negedge clk); sb_addr = a; sb_rd = 1'b1;
        @(negedge clk); sb_rd = 1'b0;
    endtask

    task automatic fd_pulse();
        @(negedge clk); frame_done = 1'b1;
        @(negedge clk); frame_done = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (sb_rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0000", sb_rd_data); end
        n_vec++; if ({fb_wr_en, fb_rd_en, display_en, front_buf, brightness} !== 8'h0) begin
            n_err++; $display("FAIL reset_outputs: got %b want 0", {fb_wr_en, fb_rd_en, display_en, front_buf, brightness}); end
        rst_n = 1'b1;
        idle(2);
        rd(16'd2, 16'h0000); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL reset_status: got %h want %h", sb_rd_data, e); end
        rd(16'd3, 16'h0000); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL reset_ptr: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_id();
        rd(16'd0, 16'h5032); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL id_read: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_fb_write();
        wr(16'd3, 16'h03FF);
        wr(16'd4, 16'hAAAA); exp_wr_q.push_back({11'h3FF, 16'hAAAA});
        wr(16'd4, 16'hBBBB); exp_wr_q.push_back({11'h400, 16'hBBBB});
        wr(16'd4, 16'hCCCC); exp_wr_q.push_back({11'h401, 16'hCCCC});
        idle(2);
        n_vec++; if (obs_wr_q.size() != exp_wr_q.size()) begin n_err++;
            $display("FAIL fb_write_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            ew = exp_wr_q.pop_front(); ow = obs_wr_q.pop_front();
            n_vec++; if (ow !== ew) begin n_err++; $display("FAIL fb_write: got %h want %h", ow, ew); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        rd(16'd3, 16'h0402); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL ptr_after_writes: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_wrap();
        wr(16'd3, 16'h07FF);
        wr(16'd4, 16'h1234); exp_wr_q.push_back({11'h7FF, 16'h1234});
        idle(2);
        n_vec++; if (obs_wr_q.size() != 1) begin n_err++; $display("FAIL wrap_write_count: got %0d want 1", obs_wr_q.size()); end
        if (obs_wr_q.size() > 0) begin
            ew = exp_wr_q.pop_front(); ow = obs_wr_q.pop_front();
            n_vec++; if (ow !== ew) begin n_err++; $display("FAIL wrap_write: got %h want %h", ow, ew); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        rd(16'd3, 16'h0000); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL ptr_wrap: got %h want %h", sb_rd_data, e); end
        wr(16'd3, 16'hFFFF);
        rd(16'd3, 16'h07FF); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL ptr_high_bits: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_fb_read();
        int cnt0;
        ram[5] = 16'hBEEF;
        wr(16'd3, 16'h0005);
        test_id();
        cnt0 = rd_en_cnt;
`ifdef SB_FB_READBACK_EN
        exp_rd_q.push_back(16'hBEEF);
        @(negedge clk); sb_addr = 16'd4; sb_rd = 1'b1;
        @(negedge clk); sb_rd = 1'b0;
        n_vec++; if ({fb_rd_en, fb_rd_addr} !== {1'b1, 11'h005}) begin n_err++;
            $display("FAIL fb_rd_strobe: got %b/%h want 1/005", fb_rd_en, fb_rd_addr); end
        @(negedge clk);
        e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL fb_read_data: got %h want %h", sb_rd_data, e); end
        rd(16'd3, 16'h0006); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL ptr_after_read: got %h want %h", sb_rd_data, e); end
`else
        rd(16'd4, 16'h0000); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL fb_read_zero: got %h want %h", sb_rd_data, e); end
        idle(2);
        n_vec++; if (rd_en_cnt != cnt0) begin n_err++; $display("FAIL fb_rd_en_tied: got %0d pulses want 0", rd_en_cnt - cnt0); end
        rd(16'd3, 16'h0005); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL ptr_no_incr: got %h want %h", sb_rd_data, e); end
`endif
    endtask

    task automatic test_ctrl_swap();
        wr(16'd1, 16'h00F3);
        n_vec++; if ({display_en, brightness, front_buf} !== 6'b1_1111_0) begin n_err++;
            $display("FAIL ctrl_outputs: got %b want 111110", {display_en, brightness, front_buf}); end
        rd(16'd1, 16'h00F3); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL ctrl_read: got %h want %h", sb_rd_data, e); end
        fd_pulse();
        n_vec++; if (front_buf !== 1'b1) begin n_err++; $display("FAIL swap_front: got %b want 1", front_buf); end
        rd(16'd2, 16'h0003); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL status_after_swap: got %h want %h", sb_rd_data, e); end
        rd(16'd1, 16'h00F1); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL pend_cleared: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_vsync();
        wr(16'd2, 16'h0001);
        rd(16'd2, 16'h0002); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL vsync_w1c: got %h want %h", sb_rd_data, e); end
        @(negedge clk); sb_addr = 16'd2; sb_wr_data = 16'h0001; sb_wr = 1'b1; frame_done = 1'b1;
        @(negedge clk); sb_wr = 1'b0; frame_done = 1'b0;
        rd(16'd2, 16'h0003); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL vsync_set_wins: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_swap_same_clk();
        @(negedge clk); sb_addr = 16'd1; sb_wr_data = 16'h0002; sb_wr = 1'b1; frame_done = 1'b1;
        @(negedge clk); sb_wr = 1'b0; frame_done = 1'b0;
        n_vec++; if ({front_buf, display_en} !== 2'b10) begin n_err++;
            $display("FAIL same_clk_no_swap: got %b want 10", {front_buf, display_en}); end
        rd(16'd1, 16'h0002); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL same_clk_pend: got %h want %h", sb_rd_data, e); end
        fd_pulse();
        n_vec++; if (front_buf !== 1'b0) begin n_err++; $display("FAIL deferred_swap: got %b want 0", front_buf); end
    endtask

    task automatic test_wr_rd_same_clk();
        test_id();
        @(negedge clk); sb_addr = 16'd5; sb_wr_data = 16'h1234; sb_wr = 1'b1; sb_rd = 1'b1;
        @(negedge clk); sb_wr = 1'b0; sb_rd = 1'b0;
        n_vec++; if (sb_rd_data !== 16'h5032) begin n_err++; $display("FAIL wr_rd_hold: got %h want 5032", sb_rd_data); end
        rd(16'd5, 16'h1234); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL scratch_written: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_unmapped();
        wr(16'd9, 16'hDEAD);
        rd(16'd9, 16'h0000); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL unmapped_read: got %h want %h", sb_rd_data, e); end
        rd(16'd5, 16'h1234); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL unmapped_no_alias: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_back_to_back();
        wr(16'd3, 16'h0010);
        @(negedge clk); sb_addr = 16'd4; sb_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_wr_data = 16'h1110 + 16'(i);
            exp_wr_q.push_back({11'h010 + 11'(i), 16'h1110 + 16'(i)});
            @(negedge clk);
        end
        sb_wr = 1'b0;
        idle(2);
        n_vec++; if (obs_wr_q.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", obs_wr_q.size()); end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            ew = exp_wr_q.pop_front(); ow = obs_wr_q.pop_front();
            n_vec++; if (ow !== ew) begin n_err++; $display("FAIL b2b_write: got %h want %h", ow, ew); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        rd(16'd3, 16'h0014); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL b2b_ptr: got %h want %h", sb_rd_data, e); end
    endtask

    task automatic test_reset_abort();
        @(negedge clk); sb_addr = 16'd4; sb_wr_data = 16'h5555; sb_wr = 1'b1;
        @(posedge clk); #2 rst_n = 1'b0; sb_wr = 1'b0;
        #1;
        n_vec++; if ({fb_wr_en, fb_rd_en, display_en} !== 3'b000) begin n_err++;
            $display("FAIL reset_abort: got %b want 000", {fb_wr_en, fb_rd_en, display_en}); end
        idle(1); rst_n = 1'b1; idle(1);
        rd(16'd5, 16'h0000); e = exp_rd_q.pop_front();
        n_vec++; if (sb_rd_data !== e) begin n_err++; $display("FAIL reset_scratch: got %h want %h", sb_rd_data, e); end
    endtask

    initial begin
        #1;
        test_reset();
        test_id();
        test_fb_write();
        test_wrap();
        test_fb_read();
        test_ctrl_swap();
        test_vsync();
        test_swap_same_clk();
        test_wr_rd_same_clk();
        test_unmapped();
        test_back_to_back();
        test_reset_abort();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
